// File: rtl/traffic_light_monitor_if.sv
// traffic_light_monitor_if: lamp bus from traffic_light plus the monitor's status and sticky error outputs.
// Carries cycles_cnt/max_dur only when MON_STATS_EN is defined.
interface traffic_light_monitor_if #(
   parameter int CNT_W = 16
);
   logic [2:0]       light;
   logic             err_clr;
   logic [1:0]       phase;
   logic             phase_done;
   logic [CNT_W-1:0] phase_dur;
   logic             err_onehot;
   logic             err_seq;
   logic             err_time;
`ifdef MON_STATS_EN
   logic [15:0]      cycles_cnt;
   logic [CNT_W-1:0] max_dur;
   modport master (output light, err_clr,
                   input phase, phase_done, phase_dur, err_onehot, err_seq, err_time, cycles_cnt, max_dur);
   modport slave  (input light, err_clr,
                   output phase, phase_done, phase_dur, err_onehot, err_seq, err_time, cycles_cnt, max_dur);
`else
   modport master (output light, err_clr,
                   input phase, phase_done, phase_dur, err_onehot, err_seq, err_time);
   modport slave  (input light, err_clr,
                   output phase, phase_done, phase_dur, err_onehot, err_seq, err_time);
`endif
endinterface

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: checks one-hot coding, phase order and phase duration on the traffic_light lamp bus.
// Defining MON_STATS_EN adds the cycles_cnt and max_dur statistics outputs.
module traffic_light_monitor #(
   parameter int CNT_W   = 16,
   parameter int MIN_CYC = 2,
   parameter int MAX_CYC = 1000
) (
   input logic                    clk,
   input logic                    rst_n,
   traffic_light_monitor_if.slave mon
);
   localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_CYC);
   localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CYC);
   typedef enum logic [2:0] {SYNC, RED, GREEN, YELLOW, FAULT} state_t;
   state_t           state, state_nxt, hot_st, legal_st;
   logic [2:0]       light_q;
   logic [CNT_W-1:0] cnt, cnt_inc, cnt_nxt;
   logic             onehot, stay, change, legal, tmo, set_oh, set_seq, set_time;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= SYNC;
      else state <= state_nxt;

   always_comb begin
      onehot    = light_q inside {3'b001, 3'b010, 3'b100};
      hot_st    = light_q[2] ? RED : light_q[1] ? YELLOW : GREEN;
      legal_st  = state == RED ? GREEN : state == GREEN ? YELLOW : RED;
      stay      = onehot && hot_st == state;
      change    = onehot && !stay && (state inside {RED, GREEN, YELLOW});
      legal     = change && hot_st == legal_st;
      cnt_inc   = &cnt ? cnt : cnt + 1'b1;
      cnt_nxt   = stay ? cnt_inc : onehot ? CNT_W'(1) : '0;
      // timeout fires only on the step onto MAX_V, so a saturated counter cannot re-trigger it
      tmo       = stay && cnt != cnt_inc && cnt_inc == MAX_V;
      set_oh    = !onehot;
      set_seq   = change && !legal;
      set_time  = tmo || (change && (cnt < MIN_V || cnt >= MAX_V));
      state_nxt = onehot ? hot_st : state == SYNC ? SYNC : FAULT;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         light_q        <= '0;
         cnt            <= '0;
         mon.phase_done <= 1'b0;
         mon.phase_dur  <= '0;
         mon.err_onehot <= 1'b0;
         mon.err_seq    <= 1'b0;
         mon.err_time   <= 1'b0;
      end else begin
         light_q        <= mon.light;
         cnt            <= cnt_nxt;
         mon.phase_done <= change;
         if (change) mon.phase_dur <= cnt;
         mon.err_onehot <= set_oh || (mon.err_onehot && !mon.err_clr);
         mon.err_seq    <= set_seq || (mon.err_seq && !mon.err_clr);
         mon.err_time   <= set_time || (mon.err_time && !mon.err_clr);
      end

   assign mon.phase = state == RED ? 2'd1 : state == GREEN ? 2'd2 : state == YELLOW ? 2'd3 : 2'd0;

`ifdef MON_STATS_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mon.cycles_cnt <= '0;
         mon.max_dur    <= '0;
      end else if (mon.err_clr) begin
         mon.cycles_cnt <= '0;
         mon.max_dur    <= '0;
      end else begin
         if (legal && hot_st == RED && !(&mon.cycles_cnt)) mon.cycles_cnt <= mon.cycles_cnt + 16'd1;
         if (change && cnt > mon.max_dur) mon.max_dur <= cnt;
      end
`endif
endmodule
